// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the initiator and the slave memory.
// Holds burst/response encodings, the initiator state enum, the captured
// command attribute payload and the command legality checker.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } mst_state_e;

  // Burst attributes captured from an accepted command.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_ax_attr_t;

  // True when a burst is legal: defined burst type, size-aligned start,
  // size within the data bus, no 4 KB crossing, legal WRAP length.
  // Only addr[11:0] matters for every rule, so callers pass the low bits.
  function automatic logic axi_cmd_legal(input logic [11:0] addr,
                                         input logic [7:0]  len,
                                         input logic [2:0]  size,
                                         input logic [1:0]  burst,
                                         input logic [2:0]  max_size);
    logic [11:0] align_mask;
    logic [16:0] end_ofs;
    logic        ok;
    align_mask = 12'((13'd1 << size) - 13'd1);
    end_ofs    = 17'(addr) + ((17'(len) + 17'd1) << size);
    ok = 1'b1;
    if (burst == BURST_RSVD)              ok = 1'b0;
    if ((addr & align_mask) != 12'd0)     ok = 1'b0;
    if (size > max_size)                  ok = 1'b0;
    if (end_ofs > 17'd4096)               ok = 1'b0;
    if (burst == BURST_WRAP &&
        !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/axi_master.sv
// AXI4 initiator: turns one local burst command into an AXI4 write
// (AW/W/B) or read (AR/R) transaction, one outstanding at a time.
// Ports:
//   ACLK, ARESETn                         clock, async active-low reset
//   cmd_*                                 command handshake and attributes
//   wr_data/wr_strb/wr_valid/wr_ready     write beat stream (into W)
//   rd_data/rd_last/rd_valid/rd_ready     read beat stream (from R)
//   done/resp                             one-cycle completion and response
//   AW*/W*/B*/AR*/R*                      AXI4 initiator channels
// Illegal commands complete locally with SLVERR and never touch the bus.
module axi_master
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  // command port
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [2:0]                cmd_size,
  input  logic [1:0]                cmd_burst,
  // write beat stream
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  // read beat stream
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  // completion
  output logic                      done,
  output logic [1:0]                resp,
  // AW
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  // W
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  // B
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  // AR
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  // R
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0]  MAX_SIZE   = 3'($clog2(STRB_WIDTH));

  mst_state_e               state, state_nxt;
  logic [ADDR_WIDTH-1:0]    cap_addr;
  axi_ax_attr_t             cap_attr;
  logic [8:0]               beat_cnt;
  logic [1:0]               rresp_worst;
  logic [1:0]               rresp_max;
  logic [1:0]               resp_nxt;
  logic                     cmd_ok;
  logic                     cap_load;
  logic                     beat_dec;
  logic                     r_hs;

  assign cmd_ok = axi_cmd_legal(cmd_addr[11:0], cmd_len, cmd_size, cmd_burst, MAX_SIZE);

  // Address channels are driven straight from the captured command, so they
  // stay stable for the whole AxVALID window.
  assign AWADDR  = cap_addr;
  assign AWLEN   = cap_attr.len;
  assign AWSIZE  = cap_attr.size;
  assign AWBURST = cap_attr.burst;
  assign ARADDR  = cap_addr;
  assign ARLEN   = cap_attr.len;
  assign ARSIZE  = cap_attr.size;
  assign ARBURST = cap_attr.burst;

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, datapath controls and the pass-through beat streams.
  always_comb begin
    state_nxt = state;
    cap_load  = 1'b0;
    beat_dec  = 1'b0;
    r_hs      = 1'b0;
    resp_nxt  = RESP_OKAY;
    wr_ready  = 1'b0;
    WVALID    = 1'b0;
    WDATA     = '0;
    WSTRB     = '0;
    WLAST     = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    rresp_max = (RRESP > rresp_worst) ? RRESP : rresp_worst;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_ok) begin
            cap_load  = 1'b1;
            state_nxt = cmd_write ? ST_AW : ST_AR;
          end else begin
            state_nxt = ST_DONE;
            resp_nxt  = RESP_SLVERR;
          end
        end
      end
      ST_AW: if (AWREADY) state_nxt = ST_W;
      ST_W: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WDATA    = wr_data;
        WSTRB    = wr_strb;
        WLAST    = (beat_cnt == 9'd1);
        if (wr_valid && WREADY) begin
          beat_dec = 1'b1;
          if (beat_cnt == 9'd1) state_nxt = ST_B;
        end
      end
      ST_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          state_nxt = ST_DONE;
          resp_nxt  = BRESP;
        end
      end
      ST_AR: if (ARREADY) state_nxt = ST_R;
      ST_R: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = RLAST;
        if (RVALID && rd_ready) begin
          r_hs = 1'b1;
          // Count saturates at zero so an overlong burst still drains to RLAST.
          beat_dec = (beat_cnt != 9'd0);
          if (RLAST) begin
            state_nxt = ST_DONE;
            resp_nxt  = (beat_cnt != 9'd1) ? RESP_SLVERR : rresp_max;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered handshake outputs, completion and captured command.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cmd_ready   <= 1'b0;
      AWVALID     <= 1'b0;
      ARVALID     <= 1'b0;
      done        <= 1'b0;
      resp        <= RESP_OKAY;
      cap_addr    <= '0;
      cap_attr    <= '0;
      beat_cnt    <= '0;
      rresp_worst <= RESP_OKAY;
    end else begin
      cmd_ready <= (state_nxt == ST_IDLE);
      AWVALID   <= (state_nxt == ST_AW);
      ARVALID   <= (state_nxt == ST_AR);
      done      <= (state_nxt == ST_DONE);
      resp      <= (state_nxt == ST_DONE) ? resp_nxt : RESP_OKAY;
      if (cap_load) begin
        cap_addr    <= cmd_addr;
        cap_attr    <= '{len: cmd_len, size: cmd_size, burst: cmd_burst};
        beat_cnt    <= 9'(cmd_len) + 9'd1;
        rresp_worst <= RESP_OKAY;
      end else begin
        if (beat_dec) beat_cnt    <= beat_cnt - 9'd1;
        if (r_hs)     rresp_worst <= rresp_max;
      end
    end
  end

endmodule

// File: tb/tb_axi_master.sv
// Directed bench for axi_master with a behavioural AXI4 slave memory and
// queue scoreboards for AW/AR, W beats, read beats and completions.
module tb_axi_master;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done;
  logic [1:0]  resp;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .resp(resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } wexp_t;
  typedef struct { logic [31:0] a; logic [7:0] len; logic [2:0] sz; logic [1:0] b; } ax_t;

  int          checks = 0;
  int          fails  = 0;
  wexp_t       exp_w[$];
  ax_t         exp_ax[$];
  logic [32:0] exp_r[$];
  logic [1:0]  exp_resp[$];
  logic [31:0] wsrc[$];

  // slave model state
  logic [31:0] mem [0:1023];
  ax_t         s_aw, s_ar, aw_snap;
  int          aw_delay = 0, aw_cnt = 0, aw_vcyc = 0;
  int          w_beat = 0, r_beat = 0, r_last_at = 0, early_last = -1;
  bit          aw_seen = 0, b_pend = 0, r_active = 0, aw_snap_ok = 0;
  // run bookkeeping
  bit          accepted = 0, done_seen = 0, no_bus = 0;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0, done_total = 0, w_hs_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] beat_addr(input ax_t x, input int beat);
    logic [31:0] nb, wb;
    nb = 32'(beat) << x.sz;
    wb = (32'(x.len) + 32'd1) << x.sz;
    case (x.b)
      2'b01:   return x.a + nb;
      2'b10:   return (x.a & ~(wb - 32'd1)) | ((x.a + nb) & (wb - 32'd1));
      default: return x.a;
    endcase
  endfunction

  task automatic ax_hs(input string tag, input ax_t got);
    ax_t e;
    chk({tag, "_expected"}, 64'(exp_ax.size() != 0), 64'd1);
    if (exp_ax.size() != 0) begin
      e = exp_ax.pop_front();
      chk(tag, 64'({got.a, got.len, got.sz, got.b}), 64'({e.a, e.len, e.sz, e.b}));
    end
  endtask

  // Slave-side drive for the coming clock edge.
  task automatic slave_drive();
    logic [31:0] ba;
    if (AWVALID) begin
      AWREADY = (aw_cnt >= aw_delay);
      aw_cnt++;
    end else begin
      AWREADY = 1'b0;
      aw_cnt  = 0;
    end
    WREADY  = 1'b1;
    BVALID  = b_pend;
    BRESP   = RESP_OKAY;
    ARREADY = ARVALID;
    RRESP   = RESP_OKAY;
    if (r_active) begin
      ba     = beat_addr(s_ar, r_beat);
      RVALID = 1'b1;
      RDATA  = mem[ba[11:2]];
      RLAST  = (r_beat == r_last_at);
    end else begin
      RVALID = 1'b0;
      RDATA  = '0;
      RLAST  = 1'b0;
    end
  endtask

  // Observe settled outputs; every handshake seen here happens at the next edge.
  task automatic observe();
    logic [31:0] ba, m;
    wexp_t       e;
    logic [32:0] er;
    cyc++;
    if (cmd_valid && cmd_ready) begin accepted = 1; acc_cyc = cyc; end
    if (no_bus) chk("no_bus", 64'({AWVALID, ARVALID, wr_ready}), 64'd0);
    if (AWVALID) begin
      aw_vcyc++;
      if (!aw_snap_ok) begin
        aw_snap = '{AWADDR, AWLEN, AWSIZE, AWBURST};
        aw_snap_ok = 1;
      end else
        chk("aw_stable", 64'({AWADDR, AWLEN, AWSIZE, AWBURST}),
            64'({aw_snap.a, aw_snap.len, aw_snap.sz, aw_snap.b}));
    end
    if (AWVALID && AWREADY) begin
      aw_snap_ok = 0;
      s_aw = '{AWADDR, AWLEN, AWSIZE, AWBURST};
      ax_hs("aw", s_aw);
      w_beat = 0;
      aw_seen = 1;
    end
    if (wr_valid && wr_ready && wsrc.size() != 0) void'(wsrc.pop_front());
    if (WVALID && WREADY) begin
      w_hs_total++;
      chk("w_after_aw", 64'(aw_seen), 64'd1);
      chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
      if (exp_w.size() != 0) begin
        e = exp_w.pop_front();
        chk("w_beat", 64'({WDATA, WSTRB, WLAST}), 64'({e.d, e.s, e.l}));
      end
      ba = beat_addr(s_aw, w_beat);
      m  = mem[ba[11:2]];
      for (int i = 0; i < 4; i++) if (WSTRB[i]) m[8*i +: 8] = WDATA[8*i +: 8];
      mem[ba[11:2]] = m;
      w_beat++;
      if (WLAST) begin b_pend = 1; aw_seen = 0; end
    end
    if (BVALID && BREADY) b_pend = 0;
    if (ARVALID && ARREADY) begin
      s_ar = '{ARADDR, ARLEN, ARSIZE, ARBURST};
      ax_hs("ar", s_ar);
      r_beat = 0;
      r_last_at = (early_last >= 0) ? early_last : int'(ARLEN);
      r_active = 1;
    end
    if (rd_valid && rd_ready) begin
      chk("rd_expected", 64'(exp_r.size() != 0), 64'd1);
      if (exp_r.size() != 0) begin
        er = exp_r.pop_front();
        chk("rd_beat", 64'({rd_last, rd_data}), 64'(er));
      end
    end
    if (RVALID && RREADY) begin
      if (RLAST) r_active = 0;
      r_beat++;
    end
    if (done) begin
      done_seen = 1;
      done_cyc = cyc;
      done_total++;
      chk("done_expected", 64'(exp_resp.size() != 0), 64'd1);
      if (exp_resp.size() != 0) chk("resp", 64'(resp), 64'(exp_resp.pop_front()));
    end
  endtask

  // Called at a falling edge after inputs are set; returns at the next one.
  task automatic step();
    slave_drive();
    #1;
    observe();
    @(negedge ACLK);
  endtask

  task automatic push_wr(input logic [31:0] d, input logic last);
    wsrc.push_back(d);
    exp_w.push_back('{d, 4'hF, last});
  endtask

  task automatic drive_streams(input int n, input bit toggle_rd);
    wr_valid = (wsrc.size() != 0);
    wr_data  = wr_valid ? wsrc[0] : 32'h0;
    wr_strb  = 4'hF;
    rd_ready = toggle_rd ? n[0] : 1'b1;
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit legal,
                         input logic [1:0] eresp, input int budget, input bit toggle_rd);
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    if (legal) exp_ax.push_back('{addr, len, size, burst});
    exp_resp.push_back(eresp);
    accepted = 0;
    done_seen = 0;
    for (int n = 0; n < budget && !done_seen; n++) begin
      drive_streams(n, toggle_rd);
      step();
      if (accepted) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    chk("done_in_budget", 64'(done_seen), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_hs"}, 64'({cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY,
                          wr_ready, rd_valid, done}), 64'd0);
    chk({tag, "_resp"}, 64'(resp), 64'd0);
    chk({tag, "_addr"}, {AWADDR, ARADDR}, 64'd0);
    chk({tag, "_attr"}, 64'({AWLEN, AWSIZE, AWBURST, ARLEN, ARSIZE, ARBURST}), 64'd0);
    chk({tag, "_wdata"}, 64'({WDATA, WSTRB, WLAST, rd_data, rd_last}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dt_before;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
    wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);

    // Reset values, then cmd_ready one edge after release.
    repeat (2) @(negedge ACLK);
    #1 check_reset("rst");
    @(negedge ACLK);
    ARESETn = 1'b1;
    step();
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

    // INCR write 0x10 len 3 data 1..4, then read it back.
    for (int i = 1; i <= 4; i++) push_wr(32'(i), i == 4);
    run_cmd(1'b1, 32'h10, 8'd3, 3'd2, 2'b01, 1, RESP_OKAY, 60, 0);
    chk("wr1_drained", 64'(exp_w.size()), 64'd0);
    for (int i = 1; i <= 4; i++) exp_r.push_back({i == 4, 32'(i)});
    run_cmd(1'b0, 32'h10, 8'd3, 3'd2, 2'b01, 1, RESP_OKAY, 60, 0);
    chk("rd1_drained", 64'(exp_r.size()), 64'd0);

    // WRAP read at 0x0C: words 3,0,1,2.
    exp_r.push_back({1'b0, 32'hA000_0003});
    exp_r.push_back({1'b0, 32'hA000_0000});
    exp_r.push_back({1'b0, 32'hA000_0001});
    exp_r.push_back({1'b1, 32'hA000_0002});
    run_cmd(1'b0, 32'h0C, 8'd3, 3'd2, 2'b10, 1, RESP_OKAY, 60, 0);
    chk("wrap_drained", 64'(exp_r.size()), 64'd0);

    // 4 KB crossing write: rejected locally, no beats consumed.
    for (int i = 0; i < 4; i++) wsrc.push_back(32'h5500 + 32'(i));
    no_bus = 1;
    run_cmd(1'b1, 32'hFF8, 8'd3, 3'd2, 2'b01, 0, RESP_SLVERR, 20, 0);
    chk("rej_latency", 64'(done_cyc - acc_cyc), 64'd1);
    chk("rej_no_consume", 64'(wsrc.size()), 64'd4);
    wsrc.delete();
    // Oversize, misaligned, bad WRAP length, reserved burst.
    run_cmd(1'b0, 32'h0, 8'd3, 3'd3, 2'b01, 0, RESP_SLVERR, 20, 0);
    run_cmd(1'b0, 32'h2, 8'd0, 3'd2, 2'b01, 0, RESP_SLVERR, 20, 0);
    run_cmd(1'b0, 32'h0, 8'd2, 3'd2, 2'b10, 0, RESP_SLVERR, 20, 0);
    run_cmd(1'b0, 32'h0, 8'd0, 3'd2, 2'b11, 0, RESP_SLVERR, 20, 0);
    no_bus = 0;

    // Ends exactly on the 4 KB boundary: legal.
    for (int i = 0; i < 4; i++) push_wr(32'hB000 + 32'(i), i == 3);
    run_cmd(1'b1, 32'hFF0, 8'd3, 3'd2, 2'b01, 1, RESP_OKAY, 60, 0);
    chk("bnd_mem", 64'(mem[1023]), 64'h0000_B003);

    // AWREADY held off 5 cycles; then len-7 read with rd_ready toggling.
    aw_delay = 5; aw_vcyc = 0;
    for (int i = 0; i < 8; i++) push_wr(32'h100 + 32'(i), i == 7);
    run_cmd(1'b1, 32'h40, 8'd7, 3'd2, 2'b01, 1, RESP_OKAY, 80, 0);
    chk("aw_wait_cycles", 64'(aw_vcyc), 64'd6);
    aw_delay = 0;
    for (int i = 0; i < 8; i++) exp_r.push_back({i == 7, 32'h100 + 32'(i)});
    run_cmd(1'b0, 32'h40, 8'd7, 3'd2, 2'b01, 1, RESP_OKAY, 80, 1);
    chk("toggle_drained", 64'(exp_r.size()), 64'd0);

    // Early RLAST on beat 2 of a len-3 read.
    early_last = 1;
    exp_r.push_back({1'b0, 32'hA000_0020});
    exp_r.push_back({1'b1, 32'hA000_0021});
    run_cmd(1'b0, 32'h80, 8'd3, 3'd2, 2'b01, 1, RESP_SLVERR, 40, 0);
    early_last = -1;

    // Reset during W beat 2 of a len-7 write.
    for (int i = 0; i < 8; i++) push_wr(32'h300 + 32'(i), i == 7);
    cmd_write = 1; cmd_addr = 32'h100; cmd_len = 8'd7; cmd_size = 3'd2; cmd_burst = 2'b01;
    cmd_valid = 1;
    exp_ax.push_back('{32'h100, 8'd7, 3'd2, 2'b01});
    accepted = 0;
    dt_before = w_hs_total;
    for (int n = 0; n < 30 && (w_hs_total - dt_before) < 1; n++) begin
      drive_streams(n, 0);
      step();
      if (accepted) cmd_valid = 1'b0;
    end
    cmd_valid = 0;
    chk("reached_beat2", 64'(w_hs_total - dt_before), 64'd1);
    dt_before = done_total;
    ARESETn = 1'b0;
    #1 check_reset("midrst");
    wr_valid = 0;
    exp_w.delete(); wsrc.delete(); exp_ax.delete();
    aw_seen = 0; b_pend = 0; r_active = 0; aw_snap_ok = 0;
    @(negedge ACLK);
    step();
    ARESETn = 1'b1;
    step();
    step();
    chk("no_done_abort", 64'(done_total), 64'(dt_before));
    chk("ready_after_abort", 64'(cmd_ready), 64'd1);
    push_wr(32'hDEAD_0001, 1'b0);
    push_wr(32'hDEAD_0002, 1'b1);
    run_cmd(1'b1, 32'h200, 8'd1, 3'd2, 2'b01, 1, RESP_OKAY, 40, 0);
    exp_r.push_back({1'b0, 32'hDEAD_0001});
    exp_r.push_back({1'b1, 32'hDEAD_0002});
    run_cmd(1'b0, 32'h200, 8'd1, 3'd2, 2'b01, 1, RESP_OKAY, 40, 0);
    chk("final_queues", 64'(exp_r.size() + exp_w.size() + exp_resp.size() + exp_ax.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
